teclado_cajero: RTL and testbench

- Keypad/card-slot front end for the ATM transaction controller; drives the controller's input side.
- Debounces raw keypad presses and detects card insertion (one-cycle `tarjeta_recibida`).
- In PIN entry, forwards each digit as `digito` with a one-cycle `digito_stb`.
- In amount entry, accumulates decimal digits into `monto`, latches `tipo_trans` and pulses `monto_stb` on enter.

---
 rtl/teclado_cajero.sv | 130 +++++++++++++
 tb/tb_teclado_cajero.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/teclado_cajero.sv
// teclado_cajero: debounced keypad and card-slot front end that feeds PIN digits and amounts to the ATM controller
module teclado_cajero #(
  parameter int DEBOUNCE_CICLOS   = 4,
  parameter int PIN_DIGITOS       = 4,
  parameter int MONTO_MAX_DIGITOS = 9
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tarjeta_insertada,
  input  logic        tecla_presionada,
  input  logic [3:0]  tecla_codigo,
  output logic        tarjeta_recibida,
  output logic [3:0]  digito,
  output logic        digito_stb,
  output logic        tipo_trans,
  output logic [31:0] monto,
  output logic        monto_stb,
  output logic        cancelado
);
  localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
  localparam int PW = $clog2(PIN_DIGITOS + 1);
  localparam int NW = $clog2(MONTO_MAX_DIGITOS + 1);
  typedef enum logic [1:0] {IDLE, PIN, MONTO} estado_t;
  estado_t estado, estado_n;
  logic          tarjeta_q, presion_q, armado, acepta, es_digito;
  logic [3:0]    codigo_q, digito_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] pin_cnt, pin_n;
  logic [NW-1:0] ndig, ndig_n;
  logic [31:0]   acc, acc_n, monto_n;
  logic          recibida_n, dstb_n, tipo_n, mstb_n, cancel_n;
  always_comb begin
    cnt_n = !tecla_presionada ? '0
          : (presion_q && tecla_codigo == codigo_q) ? (cnt == CW'(DEBOUNCE_CICLOS) ? cnt : cnt + CW'(1))
          : CW'(1);
    acepta = armado && cnt_n == CW'(DEBOUNCE_CICLOS);
    es_digito = tecla_codigo <= 4'd9;
    estado_n = estado;
    pin_n = pin_cnt;
    ndig_n = ndig;
    acc_n = acc;
    digito_n = digito;
    tipo_n = tipo_trans;
    monto_n = monto;
    recibida_n = 1'b0;
    dstb_n = 1'b0;
    mstb_n = 1'b0;
    cancel_n = 1'b0;
    if (estado == IDLE) begin
      if (tarjeta_insertada && !tarjeta_q) begin
        recibida_n = 1'b1;
        estado_n = PIN;
        pin_n = '0;
      end
    end else if (!tarjeta_insertada || (acepta && tecla_codigo == 4'hC)) begin
      // card removal outranks any key accepted in the same cycle
      cancel_n = 1'b1;
      estado_n = IDLE;
      pin_n = '0;
      acc_n = '0;
      ndig_n = '0;
    end else if (acepta && estado == PIN) begin
      if (es_digito) begin
        digito_n = tecla_codigo;
        dstb_n = 1'b1;
        pin_n = pin_cnt + PW'(1);
        if (pin_cnt == PW'(PIN_DIGITOS - 1)) begin
          estado_n = MONTO;
          pin_n = '0;
          acc_n = '0;
          ndig_n = '0;
          tipo_n = 1'b0;
        end
      end
    end else if (acepta && estado == MONTO) begin
      if (es_digito && ndig < NW'(MONTO_MAX_DIGITOS)) begin
        acc_n = acc * 32'd10 + {28'd0, tecla_codigo};
        ndig_n = ndig + NW'(1);
      end else if (tecla_codigo == 4'hB) begin
        acc_n = '0;
        ndig_n = '0;
      end else if (tecla_codigo == 4'hD || tecla_codigo == 4'hE) begin
        tipo_n = tecla_codigo == 4'hE;
      end else if (tecla_codigo == 4'hA && ndig != '0) begin
        monto_n = acc;
        mstb_n = 1'b1;
        estado_n = IDLE;
        acc_n = '0;
        ndig_n = '0;
      end
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado <= IDLE;
      tarjeta_q <= 1'b0;
      presion_q <= 1'b0;
      codigo_q <= '0;
      cnt <= '0;
      armado <= 1'b1;
      pin_cnt <= '0;
      ndig <= '0;
      acc <= '0;
      tarjeta_recibida <= 1'b0;
      digito <= '0;
      digito_stb <= 1'b0;
      tipo_trans <= 1'b0;
      monto <= '0;
      monto_stb <= 1'b0;
      cancelado <= 1'b0;
    end else begin
      estado <= estado_n;
      tarjeta_q <= tarjeta_insertada;
      presion_q <= tecla_presionada;
      codigo_q <= tecla_codigo;
      cnt <= cnt_n;
      armado <= !tecla_presionada ? 1'b1 : acepta ? 1'b0 : armado;
      pin_cnt <= pin_n;
      ndig <= ndig_n;
      acc <= acc_n;
      tarjeta_recibida <= recibida_n;
      digito <= digito_n;
      digito_stb <= dstb_n;
      tipo_trans <= tipo_n;
      monto <= monto_n;
      monto_stb <= mstb_n;
      cancelado <= cancel_n;
    end
  end
endmodule

// File: tb/tb_teclado_cajero.sv
// tb_teclado_cajero: scoreboard bench; stimulus queues expected pulses, a negedge monitor pops and compares them
module tb_teclado_cajero;
  localparam int D = 4;
  localparam int K_REC = 0, K_DIG = 1, K_MONTO = 2, K_CANCEL = 3, K_NONE = -1;
  logic        clock = 1'b0, reset = 1'b1;
  logic        tarjeta_insertada = 1'b0, tecla_presionada = 1'b0;
  logic [3:0]  tecla_codigo = 4'h0;
  logic        tarjeta_recibida, digito_stb, tipo_trans, monto_stb, cancelado;
  logic [3:0]  digito;
  logic [31:0] monto;
  int vectors = 0, miscompares = 0, cyc = 0;
  typedef struct {int kind; logic [31:0] val; int at;} ev_t;
  ev_t q[$];

  teclado_cajero #(.DEBOUNCE_CICLOS(D), .PIN_DIGITOS(4), .MONTO_MAX_DIGITOS(9)) dut (
    .clock(clock), .reset(reset), .tarjeta_insertada(tarjeta_insertada),
    .tecla_presionada(tecla_presionada), .tecla_codigo(tecla_codigo),
    .tarjeta_recibida(tarjeta_recibida), .digito(digito), .digito_stb(digito_stb),
    .tipo_trans(tipo_trans), .monto(monto), .monto_stb(monto_stb), .cancelado(cancelado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    int n, kind;
    logic [31:0] val;
    ev_t e;
    n = int'(tarjeta_recibida) + int'(digito_stb) + int'(monto_stb) + int'(cancelado);
    if (!reset && n != 0) begin
      kind = tarjeta_recibida ? K_REC : digito_stb ? K_DIG : monto_stb ? K_MONTO : K_CANCEL;
      val = kind == K_DIG ? {28'd0, digito} : kind == K_MONTO ? monto : 32'd0;
      vectors++;
      if (n > 1) begin
        miscompares++;
        $display("FAIL pulse_onehot: got %0d pulses at cyc %0d, want 1", n, cyc);
      end else if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: got kind=%0d val=%0d at cyc %0d, want none", kind, val, cyc);
      end else begin
        e = q.pop_front();
        if (e.kind != kind || e.val != val || e.at != cyc) begin
          miscompares++;
          $display("FAIL event: got kind=%0d val=%0d cyc=%0d, want kind=%0d val=%0d cyc=%0d",
                   kind, val, cyc, e.kind, e.val, e.at);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [31:0] val, input int at);
    if (kind != K_NONE) q.push_back('{kind, val, at});
  endtask

  task automatic key(input logic [3:0] k, input int hold, input int kind, input logic [31:0] val);
    tecla_codigo = k;
    tecla_presionada = 1'b1;
    expect_ev(kind, val, cyc + D);
    repeat (hold) @(negedge clock);
    tecla_presionada = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic card(input logic v, input int kind);
    tarjeta_insertada = v;
    expect_ev(kind, 32'd0, cyc + 1);
    repeat (2) @(negedge clock);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clock);
    chk(name, q.size(), 0);
  endtask

  task automatic pin4(input logic [3:0] a, b, c, d);
    key(a, 6, K_DIG, {28'd0, a});
    key(b, 6, K_DIG, {28'd0, b});
    key(c, 6, K_DIG, {28'd0, c});
    key(d, 6, K_DIG, {28'd0, d});
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_recibida", tarjeta_recibida, 0);
    chk("rst_digito", digito, 0);
    chk("rst_tipo", tipo_trans, 0);
    chk("rst_monto", monto, 0);
    reset = 1'b0;
    @(negedge clock);
    key(4'h5, 6, K_NONE, 0);
    card(1'b1, K_REC);
    pin4(4'h1, 4'h2, 4'h3, 4'h4);
    key(4'hE, 6, K_NONE, 0);
    key(4'h2, 6, K_NONE, 0);
    key(4'h5, 6, K_NONE, 0);
    key(4'h0, 6, K_NONE, 0);
    key(4'hA, 6, K_MONTO, 32'd250);
    drain("drain_250");
    chk("tipo_retiro", tipo_trans, 1);
    key(4'h3, 6, K_NONE, 0);
    card(1'b0, K_NONE);
    card(1'b1, K_REC);
    tecla_codigo = 4'h5;
    tecla_presionada = 1'b1;
    repeat (2) @(negedge clock);
    tecla_codigo = 4'h7;
    expect_ev(K_DIG, 32'd7, cyc + D);
    repeat (20) @(negedge clock);
    tecla_presionada = 1'b0;
    repeat (2) @(negedge clock);
    key(4'h1, 6, K_DIG, 32'd1);
    key(4'h2, 6, K_DIG, 32'd2);
    key(4'h3, 6, K_DIG, 32'd3);
    drain("drain_bounce");
    chk("tipo_reset_monto", tipo_trans, 0);
    key(4'h9, 6, K_NONE, 0);
    key(4'h9, 6, K_NONE, 0);
    key(4'hB, 6, K_NONE, 0);
    key(4'h4, 6, K_NONE, 0);
    key(4'h2, 6, K_NONE, 0);
    key(4'hA, 6, K_MONTO, 32'd42);
    drain("drain_42");
    card(1'b0, K_NONE);
    card(1'b1, K_REC);
    pin4(4'h0, 4'h0, 4'h0, 4'h0);
    key(4'hA, 6, K_NONE, 0);
    key(4'hE, 6, K_NONE, 0);
    for (int i = 0; i < 10; i++) key(4'h9, 6, K_NONE, 0);
    key(4'hD, 6, K_NONE, 0);
    key(4'hA, 6, K_MONTO, 32'd999999999);
    drain("drain_max");
    chk("tipo_deposito", tipo_trans, 0);
    card(1'b0, K_NONE);
    card(1'b1, K_REC);
    key(4'h1, 6, K_DIG, 32'd1);
    key(4'h2, 6, K_DIG, 32'd2);
    card(1'b0, K_CANCEL);
    key(4'h3, 6, K_NONE, 0);
    drain("drain_removal");
    card(1'b1, K_REC);
    pin4(4'h8, 4'h7, 4'h6, 4'h5);
    key(4'h5, 6, K_NONE, 0);
    key(4'hC, 6, K_CANCEL, 0);
    drain("drain_cancel");
    chk("monto_held", monto, 32'd999999999);
    card(1'b0, K_NONE);
    card(1'b1, K_REC);
    pin4(4'h6, 4'h6, 4'h6, 4'h6);
    key(4'hE, 6, K_NONE, 0);
    key(4'h8, 6, K_NONE, 0);
    drain("drain_pre_reset");
    chk("pre_reset_tipo", tipo_trans, 1);
    #2;
    reset = 1'b1;
    tarjeta_insertada = 1'b0;
    #1;
    chk("async_tipo", tipo_trans, 0);
    chk("async_monto", monto, 0);
    chk("async_digito", digito, 0);
    chk("async_pulses", {tarjeta_recibida, digito_stb, monto_stb, cancelado}, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    key(4'h6, 6, K_NONE, 0);
    card(1'b1, K_REC);
    drain("drain_final");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t, want finish", $time);
    $fatal(1);
  end
endmodule
